muldiv_seq: RTL and testbench

- Multi-cycle sequencer for MULT/MULTU/DIV/DIVU.
- Borrows the shared single-cycle ALU from the EX stage and iterates shift-add multiply or restoring divide through it.
- Stalls the pipeline while it owns the ALU and holds results in HI/LO.
- Sits between EX-stage operand muxing and the ALU inputs.

---
 rtl/muldiv_seq.sv | 197 +++++++++++++++++++
 tb/tb_muldiv_seq.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer that iterates through the shared EX-stage ALU.
// Optional MULDIV_STALL_CNT_EN adds a saturating stall-cycle counter output (stall_cnt).
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  input  logic [4:0]      ex_alu_op,
  input  logic [XLEN-1:0] ex_arg1,
  input  logic [XLEN-1:0] ex_arg2,
  input  logic [XLEN-1:0] alu_result,
  output logic [4:0]      alu_op,
  output logic [XLEN-1:0] alu_arg1,
  output logic [XLEN-1:0] alu_arg2,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic            div_by_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
`ifdef MULDIV_STALL_CNT_EN
  ,
  output logic [31:0]     stall_cnt
`endif
);

  // state   | meaning
  // IDLE    | ALU passed through to EX, waiting for start
  // NEG_A   | absolute value of operand A in lo
  // NEG_B   | absolute value of operand B in mcand
  // ITER    | XLEN shift-add / restoring-divide steps
  // FIX_LO  | apply result sign to lo
  // FIX_HI  | apply result sign to hi, divide-by-zero override
  // DONE    | one-cycle done pulse, ALU passed through
  typedef enum logic [2:0] {
    S_IDLE, S_NEG_A, S_NEG_B, S_ITER, S_FIX_LO, S_FIX_HI, S_DONE
  } state_t;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_NOR = 5'b00100;
  localparam int CW = $clog2(XLEN);

  state_t          state;
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] rs_orig;
  logic            neg_a;
  logic            neg_b;
  logic            is_div;
  logic            dz;
  logic [CW-1:0]   cnt;

  logic [XLEN-1:0] rem_s;
  logic            take;
  logic            negate;
  logic            carry;

  assign rem_s  = {hi[XLEN-2:0], lo[XLEN-1]};
  assign take   = hi[XLEN-1] | (rem_s >= mcand);
  assign negate = neg_a ^ neg_b;
  assign carry  = (alu_result < hi);

  assign busy  = (state != S_IDLE);
  assign done  = (state == S_DONE);
  assign stall = ((state != S_IDLE) && (state != S_DONE)) || (start && (state == S_IDLE));

  always_comb begin
    alu_op   = ex_alu_op;
    alu_arg1 = ex_arg1;
    alu_arg2 = ex_arg2;
    case (state)
      S_NEG_A, S_FIX_LO: begin
        alu_op   = ALU_SUB;
        alu_arg1 = '0;
        alu_arg2 = lo;
      end
      S_NEG_B: begin
        alu_op   = ALU_SUB;
        alu_arg1 = '0;
        alu_arg2 = mcand;
      end
      S_ITER: begin
        if (is_div) begin
          alu_op   = ALU_SUB;
          alu_arg1 = rem_s;
          alu_arg2 = mcand;
        end else begin
          alu_op   = ALU_ADD;
          alu_arg1 = hi;
          alu_arg2 = lo[0] ? mcand : '0;
        end
      end
      S_FIX_HI: begin
        // A zero low word means the +1 of the 64-bit negation carried into hi.
        if (!is_div && (lo != '0)) begin
          alu_op   = ALU_NOR;
          alu_arg1 = hi;
          alu_arg2 = hi;
        end else begin
          alu_op   = ALU_SUB;
          alu_arg1 = '0;
          alu_arg2 = hi;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      hi          <= '0;
      lo          <= '0;
      mcand       <= '0;
      rs_orig     <= '0;
      neg_a       <= 1'b0;
      neg_b       <= 1'b0;
      is_div      <= 1'b0;
      dz          <= 1'b0;
      cnt         <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            hi          <= '0;
            lo          <= rs_val;
            mcand       <= rt_val;
            rs_orig     <= rs_val;
            neg_a       <= op[0] & rs_val[XLEN-1];
            neg_b       <= op[0] & rt_val[XLEN-1];
            is_div      <= op[1];
            dz          <= op[1] & (rt_val == '0);
            div_by_zero <= 1'b0;
            state       <= S_NEG_A;
          end
        end
        S_NEG_A: begin
          if (neg_a) lo <= alu_result;
          state <= S_NEG_B;
        end
        S_NEG_B: begin
          if (neg_b) mcand <= alu_result;
          cnt   <= CW'(XLEN - 1);
          state <= S_ITER;
        end
        S_ITER: begin
          if (is_div) begin
            if (take) begin
              hi <= alu_result;
              lo <= {lo[XLEN-2:0], 1'b1};
            end else begin
              hi <= rem_s;
              lo <= {lo[XLEN-2:0], 1'b0};
            end
          end else begin
            {hi, lo} <= {carry, alu_result, lo[XLEN-1:1]};
          end
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= S_FIX_LO;
        end
        S_FIX_LO: begin
          if (negate) lo <= alu_result;
          state <= S_FIX_HI;
        end
        S_FIX_HI: begin
          if (dz) begin
            hi          <= rs_orig;
            lo          <= '1;
            div_by_zero <= 1'b1;
          end else if (is_div ? neg_a : negate) begin
            // Remainder follows the dividend sign; product uses the combined sign.
            hi <= alu_result;
          end
          state <= S_DONE;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MULDIV_STALL_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq with a behavioural model of the shared ALU.
module tb_muldiv_seq;
  localparam int XLEN = 32;
  localparam logic [1:0] MULTU = 2'b00;
  localparam logic [1:0] MULT  = 2'b01;
  localparam logic [1:0] DIVU  = 2'b10;
  localparam logic [1:0] DIV   = 2'b11;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] rs_val, rt_val;
  logic [4:0]      ex_alu_op;
  logic [XLEN-1:0] ex_arg1, ex_arg2;
  logic [XLEN-1:0] alu_result;
  logic [4:0]      alu_op;
  logic [XLEN-1:0] alu_arg1, alu_arg2;
  logic            busy, stall, done, div_by_zero;
  logic [XLEN-1:0] hi, lo;
`ifdef MULDIV_STALL_CNT_EN
  logic [31:0]     stall_cnt;
`endif

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int k_edge = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  muldiv_seq #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val),
    .ex_alu_op(ex_alu_op), .ex_arg1(ex_arg1), .ex_arg2(ex_arg2),
    .alu_result(alu_result), .alu_op(alu_op), .alu_arg1(alu_arg1), .alu_arg2(alu_arg2),
    .busy(busy), .stall(stall), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
`ifdef MULDIV_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always_comb begin
    case (alu_op)
      5'b00000: alu_result = alu_arg1 + alu_arg2;
      5'b00001: alu_result = alu_arg1 - alu_arg2;
      5'b00100: alu_result = ~(alu_arg1 | alu_arg2);
      default:  alu_result = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 with the sequencer idle; returns at posedge+1 after the start edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; rs_val = a; rt_val = b; start = 1'b1;
    #1;
    chk("stall_on_start", stall, 1);
    @(posedge clk); #1;
    k_edge = cyc;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic finish_op(input string tag, input logic [31:0] ehi, input logic [31:0] elo,
                           input logic edz);
    int n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_latency"}, cyc - k_edge, 36);
    chk({tag, "_hi"}, hi, ehi);
    chk({tag, "_lo"}, lo, elo);
    chk({tag, "_dbz"}, div_by_zero, edz);
    chk({tag, "_stall_in_done"}, stall, 0);
    chk({tag, "_arg1_in_done"}, alu_arg1, 32'd3);
    chk({tag, "_arg2_in_done"}, alu_arg2, 32'd4);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_hi_hold"}, hi, ehi);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
    ex_alu_op = 5'b00000; ex_arg1 = 32'd3; ex_arg2 = 32'd4;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_stall", stall, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_dbz", div_by_zero, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    chk("idle_alu_op", {27'd0, alu_op}, 0);
    chk("idle_arg1", alu_arg1, 32'd3);
    chk("idle_arg2", alu_arg2, 32'd4);
    chk("idle_result", alu_result, 32'd7);
    chk("idle_stall", stall, 0);

    issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    finish_op("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);

    issue(MULT, 32'hFFFF_FFFD, 32'd7);
    finish_op("mult_m3x7", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);

    issue(MULT, 32'h8000_0000, 32'h8000_0000);
    finish_op("mult_min_sq", 32'h4000_0000, 32'h0000_0000, 1'b0);

    issue(MULT, 32'hFFFF_0000, 32'h0001_0000);
    finish_op("mult_lo_zero", 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);

    issue(DIV, 32'hFFFF_FFF9, 32'd2);
    finish_op("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);

    issue(DIV, 32'd7, 32'hFFFF_FFFE);
    finish_op("div_7_m2", 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);

    issue(DIVU, 32'd100, 32'd7);
    finish_op("divu_100_7", 32'd2, 32'd14, 1'b0);

    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    finish_op("div_min_m1", 32'h0000_0000, 32'h8000_0000, 1'b0);

    issue(DIVU, 32'd5, 32'd0);
    finish_op("divu_by0", 32'd5, 32'hFFFF_FFFF, 1'b1);

    issue(DIVU, 32'd9, 32'd3);
    chk("dbz_clear_at_start", div_by_zero, 0);
    finish_op("divu_9_3", 32'd0, 32'd3, 1'b0);

    // Second start while busy must be ignored.
    issue(MULTU, 32'd3, 32'd5);
    repeat (4) @(posedge clk);
    #1;
    op = DIVU; rs_val = 32'd100; rt_val = 32'd100; start = 1'b1;
    #1;
    chk("busy_start_stall", stall, 1);
    chk("busy_start_busy", busy, 1);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    finish_op("ignore_start", 32'd0, 32'd15, 1'b0);

    // Reset in the middle of ITER.
    issue(MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (12) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_stall", stall, 0);
    chk("midrst_done", done, 0);
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    chk("midrst_arg1", alu_arg1, 32'd3);
    #2;
    reset = 1'b0;
    @(posedge clk); #1;
    issue(MULTU, 32'd6, 32'd7);
    finish_op("multu_6x7", 32'd0, 32'd42, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
